uart_num_parser: RTL and testbench
==================================

UART_NUM_PARSER -- requirements
Module: uart_num_parser

Interface
REQ-001 SHALL provide parameter VAL_W, default 8, width of the two's-complement output value (range 4..16).
REQ-002 SHALL provide port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port rx_data  input  8  received byte, valid only in a cycle where rx_done=1.
REQ-005 SHALL provide port rx_done  input  1  one-cycle strobe marking a new byte on rx_data.
REQ-006 SHALL provide port clear  input  1  synchronous abort of the token in progress.
REQ-007 SHALL provide port num_value  output  VAL_W  last successfully parsed signed integer.
REQ-008 SHALL provide port num_valid  output  1  one-cycle pulse: num_value just updated.
REQ-009 SHALL provide port num_err  output  1  one-cycle pulse: token rejected (bad char, lone '-', overflow).
REQ-010 SHALL provide port line_end  output  1  one-cycle pulse: CR (0x0D) or LF (0x0A) received.
REQ-011 SHALL provide port busy  output  1  high while a token is partially received (state not IDLE).

Function
REQ-012 SHALL classify bytes: digit 0x30-0x39; minus 0x2D; delimiter = space 0x20, comma 0x2C, CR, LF; anything else invalid.
REQ-013 SHALL implement states IDLE, SIGN, DIGITS, SKIP; bytes are consumed only in cycles with rx_done=1.
REQ-014 IDLE: digit -> DIGITS with acc=digit, neg=0; minus -> SIGN with acc=0, neg=1; delimiter -> stay, no num pulse; invalid -> SKIP.
REQ-015 SIGN: digit -> DIGITS with acc=digit; delimiter -> IDLE with num_err pulse; minus or invalid -> SKIP.
REQ-016 DIGITS: digit -> acc=acc*10+digit; delimiter -> IDLE with num_valid or num_err (REQ-018); minus or invalid -> SKIP.
REQ-017 SKIP: non-delimiters ignored; delimiter -> IDLE with exactly one num_err pulse per rejected token.
REQ-018 SHALL keep a sticky overflow flag set when magnitude exceeds 2^(VAL_W-1)-1 (neg=0) or 2^(VAL_W-1) (neg=1); the accumulator SHALL saturate, never wrap; on delimiter overflow gives num_err, else num_valid.
REQ-019 On num_valid, num_value SHALL equal neg ? -acc : acc truncated to VAL_W bits; "-0" yields 0.
REQ-020 num_value SHALL hold its value until the next num_valid; num_err SHALL NOT alter it.
REQ-021 Outputs SHALL be registered: pulses are high for exactly the one cycle after the clock edge that sampled the terminating rx_done.
REQ-022 CR or LF SHALL pulse line_end in any state, in the same cycle as any num_valid/num_err it causes; space and comma never pulse line_end.
REQ-023 Consecutive delimiters SHALL produce no extra num_valid/num_err pulses.
REQ-024 clear=1 SHALL force IDLE, acc=0, neg=0, overflow=0, and suppress all pulses that cycle; clear has priority over a simultaneous rx_done, whose byte is discarded.
REQ-025 Back-to-back rx_done in consecutive cycles SHALL each be processed with no byte lost.
REQ-026 busy SHALL be 1 exactly in SIGN, DIGITS and SKIP.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, acc=0, neg=0, overflow=0, num_value=0, num_valid=0, num_err=0, line_end=0, busy=0.
REQ-028 Reset asserted mid-token SHALL discard the token with no pulses after release; the first byte after release is parsed from IDLE.

Verification (VAL_W=8)
REQ-029 Bytes "12 " -> one num_valid, num_value=0x0C, no num_err, no line_end.
REQ-030 Bytes "-128\r" -> num_value=0x80 with num_valid and line_end in the same cycle; "127\n" -> 0x7F.
REQ-031 Bytes "128 " then "-129," -> two num_err pulses, num_value unchanged from prior value, no num_valid.
REQ-032 Bytes "1a3 " and "- " and "--5 " -> exactly one num_err per token, busy high from first byte until delimiter.
REQ-033 Bytes "  5,,7\n" sent back-to-back (rx_done every cycle) -> num_valid with 5, then num_valid with 7 plus line_end, nothing else.
REQ-034 "-4" then clear pulse (also with rx_done='3' in the same cycle), then "9 " -> single num_valid with num_value=9; repeat with rst_n pulse instead of clear -> same result.

Source files
------------

// File: rtl/uart_num_parser.sv
// Streaming parser that turns UART bytes into signed decimal integers.
// Tokens are optional '-' plus digits, ended by space, comma, CR or LF.
module uart_num_parser #(
    parameter int VAL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             clear,
    output logic [VAL_W-1:0] num_value,
    output logic             num_valid,
    output logic             num_err,
    output logic             line_end,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SIGN,
        DIGITS,
        SKIP
    } state_t;

    localparam int EXT_W = VAL_W + 4;
    localparam logic [VAL_W-1:0] POS_MAX = {1'b0, {(VAL_W-1){1'b1}}};
    localparam logic [VAL_W-1:0] NEG_MAX = {1'b1, {(VAL_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             lineEnd_q, lineEnd_d;
    logic             busy_q, busy_d;

    logic             isDigit, isMinus, isLineEnd, isDelim;
    logic [3:0]       digitVal;
    logic [VAL_W-1:0] baseAcc, limit, accNext, signedVal;
    logic             effNeg, over;
    logic [EXT_W-1:0] baseExt, prod;

    assign isDigit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign isMinus   = (rx_data == 8'h2D);
    assign isLineEnd = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign isDelim   = isLineEnd || (rx_data == 8'h20) || (rx_data == 8'h2C);
    assign digitVal  = rx_data[3:0];

    // A token starting from IDLE accumulates from zero with positive sign.
    assign baseAcc = (state_q == IDLE) ? {VAL_W{1'b0}} : acc_q;
    assign effNeg  = (state_q == IDLE) ? 1'b0 : neg_q;
    assign limit   = effNeg ? NEG_MAX : POS_MAX;
    assign baseExt = {4'b0000, baseAcc};
    assign prod    = (baseExt << 3) + (baseExt << 1) + {{VAL_W{1'b0}}, digitVal};
    assign over    = prod > {4'b0000, limit};
    assign accNext = over ? limit : prod[VAL_W-1:0];

    assign signedVal = neg_q ? ({VAL_W{1'b0}} - acc_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        lineEnd_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            acc_d   = {VAL_W{1'b0}};
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if (rx_done) begin
            lineEnd_d = isLineEnd;
            case (state_q)
                IDLE: begin
                    if (isDigit) begin
                        state_d = DIGITS;
                        acc_d   = accNext;
                        neg_d   = 1'b0;
                        ovf_d   = over;
                    end else if (isMinus) begin
                        state_d = SIGN;
                        acc_d   = {VAL_W{1'b0}};
                        neg_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (!isDelim) begin
                        state_d = SKIP;
                    end
                end
                SIGN: begin
                    if (isDigit) begin
                        state_d = DIGITS;
                        acc_d   = accNext;
                        ovf_d   = over;
                    end else if (isDelim) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        acc_d   = {VAL_W{1'b0}};
                        neg_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = SKIP;
                    end
                end
                DIGITS: begin
                    if (isDigit) begin
                        acc_d = accNext;
                        ovf_d = ovf_q | over;
                    end else if (isDelim) begin
                        state_d = IDLE;
                        if (ovf_q) begin
                            err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            value_d = signedVal;
                        end
                        acc_d = {VAL_W{1'b0}};
                        neg_d = 1'b0;
                        ovf_d = 1'b0;
                    end else begin
                        state_d = SKIP;
                    end
                end
                default: begin
                    // SKIP swallows the rest of a rejected token and reports it once.
                    if (isDelim) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        acc_d   = {VAL_W{1'b0}};
                        neg_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= {VAL_W{1'b0}};
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            value_q   <= {VAL_W{1'b0}};
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            lineEnd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            lineEnd_q <= lineEnd_d;
            busy_q    <= busy_d;
        end
    end

    assign num_value = value_q;
    assign num_valid = valid_q;
    assign num_err   = err_q;
    assign line_end  = lineEnd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_num_parser.sv
// Directed self-checking bench for uart_num_parser at VAL_W=8.
// Bytes are driven on the falling edge and outputs sampled 1ns after the rising edge.
module tb_uart_num_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] num_value;
    logic       num_valid, num_err, line_end, busy;

    int checks = 0;
    int failures = 0;
    int validCnt, errCnt, lineCnt;
    logic [7:0] validVals[$];
    logic       obsValid, obsErr, obsLine, obsBusy;
    logic [7:0] obsValue;

    uart_num_parser #(.VAL_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .clear(clear),
        .num_value(num_value),
        .num_valid(num_valid),
        .num_err(num_err),
        .line_end(line_end),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetCounters();
        validCnt = 0;
        errCnt   = 0;
        lineCnt  = 0;
        validVals.delete();
    endtask

    task automatic captureOutputs();
        obsValid = num_valid;
        obsErr   = num_err;
        obsLine  = line_end;
        obsBusy  = busy;
        obsValue = num_value;
        if (num_valid === 1'b1) begin
            validCnt++;
            validVals.push_back(num_value);
        end
        if (num_err === 1'b1) errCnt++;
        if (line_end === 1'b1) lineCnt++;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        captureOutputs();
    endtask

    task automatic applyString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        captureOutputs();
    endtask

    initial begin
        resetCounters();
        #12;
        checkOutput("reset_value", num_value, 8'h00);
        checkOutput("reset_valid", num_valid, 1'b0);
        checkOutput("reset_err", num_err, 1'b0);
        checkOutput("reset_line", line_end, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] token 12");
        resetCounters();
        applyStimulus("1");
        checkOutput("12_busy_first", obsBusy, 1'b1);
        applyStimulus("2");
        applyStimulus(" ");
        checkOutput("12_valid", obsValid, 1'b1);
        checkOutput("12_value", obsValue, 8'h0C);
        checkOutput("12_busy_end", obsBusy, 1'b0);
        idleCycle();
        checkOutput("12_pulse_width", obsValid, 1'b0);
        checkOutput("12_valid_cnt", validCnt, 1);
        checkOutput("12_err_cnt", errCnt, 0);
        checkOutput("12_line_cnt", lineCnt, 0);

        $display("[TB] tokens -128 and 127");
        resetCounters();
        applyString("-128\r");
        checkOutput("m128_valid", obsValid, 1'b1);
        checkOutput("m128_line", obsLine, 1'b1);
        checkOutput("m128_value", obsValue, 8'h80);
        applyString("127\n");
        checkOutput("p127_valid", obsValid, 1'b1);
        checkOutput("p127_line", obsLine, 1'b1);
        checkOutput("p127_value", obsValue, 8'h7F);
        checkOutput("m128_err_cnt", errCnt, 0);

        $display("[TB] overflow tokens");
        resetCounters();
        applyString("128 ");
        checkOutput("o128_err", obsErr, 1'b1);
        applyString("-129,");
        checkOutput("om129_err", obsErr, 1'b1);
        checkOutput("ovf_value_held", num_value, 8'h7F);
        checkOutput("ovf_err_cnt", errCnt, 2);
        checkOutput("ovf_valid_cnt", validCnt, 0);
        resetCounters();
        applyString("99999 ");
        checkOutput("sat_err_cnt", errCnt, 1);
        checkOutput("sat_valid_cnt", validCnt, 0);

        $display("[TB] malformed tokens");
        resetCounters();
        applyStimulus("1");
        checkOutput("1a3_busy0", obsBusy, 1'b1);
        applyStimulus("a");
        checkOutput("1a3_busy1", obsBusy, 1'b1);
        checkOutput("1a3_no_early_err", obsErr, 1'b0);
        applyStimulus("3");
        checkOutput("1a3_busy2", obsBusy, 1'b1);
        applyStimulus(" ");
        checkOutput("1a3_busy_end", obsBusy, 1'b0);
        checkOutput("1a3_err_cnt", errCnt, 1);
        resetCounters();
        applyStimulus("-");
        checkOutput("lone_minus_busy", obsBusy, 1'b1);
        applyStimulus(" ");
        checkOutput("lone_minus_err", obsErr, 1'b1);
        checkOutput("lone_minus_busy_end", obsBusy, 1'b0);
        resetCounters();
        applyStimulus("-");
        applyStimulus("-");
        checkOutput("mm5_busy", obsBusy, 1'b1);
        applyStimulus("5");
        applyStimulus(" ");
        checkOutput("mm5_err_cnt", errCnt, 1);
        checkOutput("bad_valid_cnt", validCnt, 0);
        checkOutput("bad_value_held", num_value, 8'h7F);

        $display("[TB] back-to-back with repeated delimiters");
        resetCounters();
        applyString("  5,,7\n");
        checkOutput("b2b_last_valid", obsValid, 1'b1);
        checkOutput("b2b_last_line", obsLine, 1'b1);
        idleCycle();
        checkOutput("b2b_valid_cnt", validCnt, 2);
        checkOutput("b2b_err_cnt", errCnt, 0);
        checkOutput("b2b_line_cnt", lineCnt, 1);
        if (validVals.size() == 2) begin
            checkOutput("b2b_first_value", validVals[0], 8'h05);
            checkOutput("b2b_second_value", validVals[1], 8'h07);
        end else begin
            checkOutput("b2b_value_count", validVals.size(), 2);
        end

        $display("[TB] minus zero");
        resetCounters();
        applyString("-0 ");
        checkOutput("m0_valid", obsValid, 1'b1);
        checkOutput("m0_value", obsValue, 8'h00);

        $display("[TB] clear mid-token");
        resetCounters();
        applyString("-4");
        @(negedge clk);
        clear   = 1'b1;
        rx_done = 1'b1;
        rx_data = "3";
        @(posedge clk);
        #1;
        clear   = 1'b0;
        rx_done = 1'b0;
        captureOutputs();
        checkOutput("clr_busy", obsBusy, 1'b0);
        checkOutput("clr_no_pulse", {obsValid, obsErr, obsLine}, 3'b000);
        applyString("9 ");
        checkOutput("clr_valid", obsValid, 1'b1);
        checkOutput("clr_value", obsValue, 8'h09);
        checkOutput("clr_valid_cnt", validCnt, 1);
        checkOutput("clr_err_cnt", errCnt, 0);

        $display("[TB] reset mid-token");
        resetCounters();
        applyString("-4");
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_value", num_value, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();
        checkOutput("rst_no_pulse", {obsValid, obsErr, obsLine}, 3'b000);
        applyString("9 ");
        checkOutput("rst_valid", obsValid, 1'b1);
        checkOutput("rst_value_after", obsValue, 8'h09);
        checkOutput("rst_valid_cnt", validCnt, 1);
        checkOutput("rst_err_cnt", errCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
